memcore_bram_pipelined: RTL and testbench
=========================================

Name: memcore_bram_pipelined

Overview:
Parametrised simple-dual-port block-RAM memory core with one write port (port 0) and one read port (port 1).
- Adds per-byte write enables, a configurable read latency of 1..4 cycles with a valid strobe, and a selectable same-address collision mode.
- Used wherever FIFOs, reorder buffers or channel buffers need deeper or wider storage than a single-cycle BRAM read meets timing at.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits covered by one write-enable bit.
- ADDRESS_WIDTH, 6: address bus width.
- ADDRESS_RANGE, 64: number of words; must be ≤ 2**ADDRESS_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to q1_valid; legal range 1..4.
- COLLISION_MODE, 0: 0 = READ_FIRST (same-cycle same-address read returns old word), 1 = WRITE_FIRST (returns old word merged with the new bytes).
- Derived: NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address0  in  ADDRESS_WIDTH  write address.
- ce0  in  1  write-port enable.
- we0  in  NUM_BYTES  byte write enables; byte i covers d0[i*BYTE_WIDTH +: BYTE_WIDTH].
- d0  in  DATA_WIDTH  write data.
- address1  in  ADDRESS_WIDTH  read address.
- ce1  in  1  read request.
- q1  out  DATA_WIDTH  read data.
- q1_valid  out  1  one-cycle strobe: q1 carries the data for a request made READ_LATENCY cycles earlier.

Behaviour:
- Write:
  - At a rising edge with ce0=1, each byte i with we0[i]=1 is written to ram[address0].
  - Bytes with we0[i]=0 are unchanged.
  - ce0=0 or we0=0 means no write.
  - If address0 ≥ ADDRESS_RANGE, the write is dropped.
- Read:
  - ce1=1 at edge T samples ram[address1] into pipeline stage 1.
  - Data moves one stage per cycle, unconditionally (no stall input).
  - q1 and q1_valid are driven from stage READ_LATENCY and appear after edge T+READ_LATENCY-1, i.e. valid during cycle T+READ_LATENCY.
  - If address1 ≥ ADDRESS_RANGE, the read returns all-zero data with valid still asserted.
- q1 hold: q1 updates only when a valid beat emerges and holds its last value otherwise. q1_valid is 0 in cycles with no emerging beat.
- Back-to-back: ce1 may be 1 every cycle. Throughput is one read plus one write per cycle.
- Collision (ce0=1, any we0 bit set, ce1=1, address0==address1, same edge):
  - Mode 0: read returns the pre-write word.
  - Mode 1: read returns the pre-write word with the written bytes replaced by d0. Non-written bytes keep their old value.
  - Writes at earlier edges are always visible to later reads in both modes.
- Reset (reset=1 at an edge):
  - All pipeline valid bits clear; q1 ← 0; q1_valid ← 0.
  - In-flight reads are discarded and never emerge.
  - RAM contents are not cleared.
  - ce0/ce1 requests in a reset cycle are ignored: no write, no read.
- Reset wins over simultaneous requests. The first read after reset deassertion behaves normally.
- Storage is inferred with ram_style "block". Pipeline registers sit outside the array so the synthesis tool can absorb the first output register into the BRAM.
- Parameters outside their legal ranges must be rejected at elaboration.

Decomposition:
- Package memcore_pkg:
  - Constants COLL_READ_FIRST=0 and COLL_WRITE_FIRST=1.
  - Function computing NUM_BYTES.
  - Elaboration-check macro for the legal ranges of READ_LATENCY and ADDRESS_RANGE.
- Sub-module memcore_rd_pipe:
  - Parametrised (WIDTH, DEPTH) valid+data delay line with synchronous reset of the valid bits and the hold-on-invalid output register.
  - Top level instantiates it once, for stages 2..READ_LATENCY plus the output register.

Test Plan:
- Full-word write then read: DATA_WIDTH=32, READ_LATENCY=1. Write 0xDEADBEEF to addr 5 (we0=4'hF); next cycle ce1 at addr 5 → q1=0xDEADBEEF with q1_valid=1 exactly one cycle after the request; q1_valid=0 the following cycle, q1 held.
- Byte merge: write 0x11223344 to addr 3, then we0=4'b0101 with d0=0xAABBCCDD → read gives 0x11BB33DD.
- Latency and streaming: READ_LATENCY=3, addrs 0..63 preloaded with value=addr, ce1 every cycle for 64 cycles → 64 consecutive valid beats 0..63, first beat 3 cycles after the first request, no gaps.
- Collision: addr 7 holds 0x0, same-edge write of 0xFFFFFFFF (we0=4'b0011) and read of addr 7 → mode 0 returns 0x00000000, mode 1 returns 0x0000FFFF; a read the next cycle returns 0x0000FFFF in both modes.
- Reset mid-flight: READ_LATENCY=4, issue reads on 3 consecutive cycles, assert reset for 1 cycle on the 4th → no q1_valid ever appears for those reads; q1=0; RAM data written before reset is still readable afterwards.
- Out-of-range: ADDRESS_RANGE=48, write to addr 50 then read addr 50 → q1=0 with q1_valid=1; addr 49 is unaffected.

Source files
------------

// File: rtl/memcore_pkg.sv
// Shared constants, helpers and elaboration checks for the pipelined BRAM memory core.
// Include this file first so the parameter-check macro is defined for the other files.
package memcore_pkg;

  localparam int COLL_READ_FIRST  = 0;
  localparam int COLL_WRITE_FIRST = 1;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

`define MEMCORE_CHECK_PARAMS(LAT, RANGE, AW) \
  if ((LAT) < 1 || (LAT) > 4) begin : g_bad_read_latency \
    $error("memcore: READ_LATENCY must be in 1..4"); \
  end \
  if ((RANGE) < 1 || (RANGE) > (1 << (AW))) begin : g_bad_address_range \
    $error("memcore: ADDRESS_RANGE must be in 1..2**ADDRESS_WIDTH"); \
  end

// File: rtl/memcore_rd_pipe.sv
// Valid+data delay line of DEPTH stages; every stage holds its data while no
// valid beat is moving into it, so the last stage doubles as the q1 hold register.
module memcore_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            valid_d, valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d,  data_q;

  // NOTE: every next-state signal is assigned on every path through always_comb,
  // otherwise the tool infers a latch to remember the unassigned case.
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift
  // on the same edge without depending on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/memcore_bram_pipelined.sv
// Simple-dual-port block RAM with byte write enables, 1..4 cycle read latency,
// a valid strobe on the read data and a selectable same-address collision mode.
module memcore_bram_pipelined
  import memcore_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int BYTE_WIDTH     = 8,
  parameter  int ADDRESS_WIDTH  = 6,
  parameter  int ADDRESS_RANGE  = 64,
  parameter  int READ_LATENCY   = 1,
  parameter  int COLLISION_MODE = 0,
  localparam int NUM_BYTES      = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic                     ce0,
  input  logic [NUM_BYTES-1:0]     we0,
  input  logic [DATA_WIDTH-1:0]    d0,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic                     ce1,
  output logic [DATA_WIDTH-1:0]    q1,
  output logic                     q1_valid
);

  `MEMCORE_CHECK_PARAMS(READ_LATENCY, ADDRESS_RANGE, ADDRESS_WIDTH)

  if (DATA_WIDTH < BYTE_WIDTH || DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
    $error("memcore: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (COLLISION_MODE != COLL_READ_FIRST && COLLISION_MODE != COLL_WRITE_FIRST) begin : g_bad_coll_mode
    $error("memcore: COLLISION_MODE must be 0 or 1");
  end

  localparam logic [ADDRESS_WIDTH:0] RANGE_L = (ADDRESS_WIDTH + 1)'(ADDRESS_RANGE);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [ADDRESS_RANGE];

  logic                  wr_in_range, rd_in_range, rd_en, merge_wr;
  logic [DATA_WIDTH-1:0] ram_rd_word, rd_word;

  always_comb begin
    wr_in_range = {1'b0, address0} < RANGE_L;
    rd_in_range = {1'b0, address1} < RANGE_L;
    rd_en       = ce1 && !reset;
    // Only write-first mode forwards same-edge write bytes into the read beat.
    merge_wr    = (COLLISION_MODE == COLL_WRITE_FIRST) && ce0 && wr_in_range
                  && (address0 == address1);
    ram_rd_word = '0;
    if (rd_in_range) begin
      ram_rd_word = mem[address1];
    end
    rd_word = ram_rd_word;
    if (merge_wr) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (we0[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = d0[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // NOTE: the storage array has no reset; clearing it would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (!reset && ce0 && wr_in_range) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (we0[b]) begin
          mem[address0][b*BYTE_WIDTH +: BYTE_WIDTH] <= d0[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  memcore_rd_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_data   (rd_word),
    .out_valid (q1_valid),
    .out_data  (q1)
  );

endmodule

// File: tb/tb_memcore_bram_pipelined.sv
// Scoreboard bench: three DUT configurations share one directed stimulus stream;
// expected beats are queued at issue and checked by a monitor on the falling edge.
module tb_memcore_bram_pipelined;

  localparam int N = 3;
  localparam int LAT  [N] = '{1, 3, 4};
  localparam int MODE [N] = '{0, 1, 0};
  localparam int RNG  [N] = '{64, 48, 64};

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, ce0, ce1;
  logic [5:0]  address0, address1;
  logic [3:0]  we0;
  logic [31:0] d0;
  logic [31:0] q1_w       [N];
  logic        q1_valid_w [N];

  exp_t        sb  [N][$];
  logic [31:0] mem [N][64];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          edge_idx = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  memcore_bram_pipelined #(.READ_LATENCY(LAT[0]), .COLLISION_MODE(MODE[0]), .ADDRESS_RANGE(RNG[0])) u0 (
    .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0),
    .address1(address1), .ce1(ce1), .q1(q1_w[0]), .q1_valid(q1_valid_w[0]));
  memcore_bram_pipelined #(.READ_LATENCY(LAT[1]), .COLLISION_MODE(MODE[1]), .ADDRESS_RANGE(RNG[1])) u1 (
    .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0),
    .address1(address1), .ce1(ce1), .q1(q1_w[1]), .q1_valid(q1_valid_w[1]));
  memcore_bram_pipelined #(.READ_LATENCY(LAT[2]), .COLLISION_MODE(MODE[2]), .ADDRESS_RANGE(RNG[2])) u2 (
    .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0),
    .address1(address1), .ce1(ce1), .q1(q1_w[2]), .q1_valid(q1_valid_w[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: flags overdue beats, unexpected beats, wrong data and wrong latency.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        while (sb[i].size() > 0 && sb[i][0].due < edge_idx) begin
          e = sb[i].pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL u%0d missing beat: no q1_valid after edge %0d, expected data %h", i, e.due, e.data);
        end
        if ($isunknown(q1_valid_w[i])) begin
          check($sformatf("u%0d q1_valid known", i), {31'b0, q1_valid_w[i]}, 32'd0);
        end else if (q1_valid_w[i]) begin
          if (sb[i].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL u%0d unexpected beat: q1_valid with q1=%h, nothing outstanding", i, q1_w[i]);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("u%0d q1 data", i), q1_w[i], e.data);
            check($sformatf("u%0d beat edge", i), 32'(edge_idx), 32'(e.due));
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; the reference memory is read before it is written.
  task automatic step(input logic rst, input logic c0, input logic [3:0] w0, input logic [5:0] a0,
                      input logic [31:0] dd, input logic c1, input logic [5:0] a1);
    reset = rst; ce0 = c0; we0 = w0; address0 = a0; d0 = dd; ce1 = c1; address1 = a1;
    @(posedge clk);
    edge_idx++;
    if (rst) begin
      for (int i = 0; i < N; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        if (c1) begin
          e.data = (int'(a1) < RNG[i]) ? mem[i][a1] : 32'h0;
          if (MODE[i] == 1 && c0 && a0 == a1 && int'(a0) < RNG[i]) begin
            for (int b = 0; b < 4; b++) if (w0[b]) e.data[8*b +: 8] = dd[8*b +: 8];
          end
          e.due = edge_idx + LAT[i] - 1;
          sb[i].push_back(e);
        end
        if (c0 && int'(a0) < RNG[i]) begin
          for (int b = 0; b < 4; b++) if (w0[b]) mem[i][a0][8*b +: 8] = dd[8*b +: 8];
        end
      end
    end
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] w);
    step(1'b0, 1'b1, w, a, d, 1'b0, 6'd0);
  endtask

  task automatic rd(input logic [5:0] a);
    step(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s u%0d q1", tag, i), q1_w[i], 32'h0);
      check($sformatf("%s u%0d q1_valid", tag, i), {31'b0, q1_valid_w[i]}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; ce0 = 1'b0; ce1 = 1'b0; we0 = '0; d0 = '0; address0 = '0; address1 = '0;
    step(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
    check_reset_state("reset");
    mon_en = 1'b1;

    for (int a = 0; a < 64; a++) wr(6'(a), 32'(a), 4'hF);

    // Full-word write, read one cycle later, then q1 must hold with valid low.
    wr(6'd5, 32'hDEADBEEF, 4'hF);
    rd(6'd5);
    check("u0 full word q1", q1_w[0], 32'hDEADBEEF);
    check("u0 full word valid", {31'b0, q1_valid_w[0]}, 32'd1);
    idle(1);
    check("u0 hold valid low", {31'b0, q1_valid_w[0]}, 32'd0);
    check("u0 hold q1", q1_w[0], 32'hDEADBEEF);

    // Byte-enable merge.
    wr(6'd3, 32'h11223344, 4'hF);
    wr(6'd3, 32'hAABBCCDD, 4'b0101);
    rd(6'd3);
    check("u0 byte merge", q1_w[0], 32'h11BB33DD);

    // Same-edge collision, then a follow-up read.
    wr(6'd7, 32'h0, 4'hF);
    step(1'b0, 1'b1, 4'b0011, 6'd7, 32'hFFFFFFFF, 1'b1, 6'd7);
    check("u0 collision read-first", q1_w[0], 32'h0);
    rd(6'd7);
    check("u0 after collision", q1_w[0], 32'h0000FFFF);
    idle(5);

    // Back-to-back streaming over the whole address space.
    for (int a = 0; a < 64; a++) rd(6'(a));
    idle(5);

    // Out-of-range write must be dropped without aliasing onto a lower address.
    wr(6'd50, 32'hCAFEF00D, 4'hF);
    rd(6'd50);
    check("u0 in-range addr 50", q1_w[0], 32'hCAFEF00D);
    rd(6'd49);
    rd(6'd47);
    rd(6'd2);
    rd(6'd18);
    idle(5);

    // Reset with reads in flight; the reset-cycle write and read are ignored.
    rd(6'd10);
    rd(6'd11);
    rd(6'd12);
    step(1'b1, 1'b1, 4'hF, 6'd10, 32'h12345678, 1'b1, 6'd10);
    check_reset_state("mid-flight reset");
    idle(6);
    rd(6'd10);
    check("u0 read after reset", q1_w[0], 32'h0000000A);
    idle(6);

    for (int i = 0; i < N; i++) check($sformatf("u%0d drained", i), 32'(sb[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
